fb_port_a_sched: RTL and testbench

Scheduler for framebuffer port A: it shares the single read/write port between the CPU load/store path and a hardware rectangle-fill engine. It sits between the core's memory-mapped framebuffer window and the framebuffer controller. Port B, the video scan-out path, is untouched. The CPU normally wins arbitration; a starvation counter guarantees the fill engine forward progress.

---
 rtl/fb_port_a_sched.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_fb_port_a_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_a_sched.sv
// -----------------------------------------------------------------------------
// fb_port_a_sched
//
// Scheduler for framebuffer port A. Shares the single read/write port between
// the CPU load/store path and a rectangle-fill engine. The CPU normally wins
// arbitration. A burst counter limits the CPU to CPU_BURST_MAX consecutive
// grants while a fill is running, so the fill engine always makes progress.
// Port B (video scan-out) is not touched by this block.
//
// Optional feature macro: FB_FILL_EN
//   defined   - fill FSM, clipping and arbitration are built
//   undefined - CPU-only pass-through; fill_start is ignored and
//               fill_busy/fill_done are tied low
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU access request (held until cpu_gnt)
//   cpu_gnt              access issued this cycle (combinational)
//   cpu_rvalid/rdata     load return, one cycle after a granted load
//   fill_start           one-cycle start pulse (ignored unless idle)
//   fill_x0/y0/w/h       rectangle origin and size in pixels
//   fill_color           fill pixel value
//   fill_busy/fill_done  engine active / one-cycle completion pulse
//   fb_addr_a/we_a/wdata_a/rdata_a  framebuffer port A (1-cycle read latency)
// -----------------------------------------------------------------------------
module fb_port_a_sched #(
    parameter int IMG_W         = 195,
    parameter int IMG_H         = 146,
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 16,
    parameter int CPU_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fill_start,
    input  logic [7:0]        fill_x0,
    input  logic [7:0]        fill_y0,
    input  logic [7:0]        fill_w,
    input  logic [7:0]        fill_h,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] fb_addr_a,
    output logic              fb_we_a,
    output logic [DATA_W-1:0] fb_wdata_a,
    input  logic [DATA_W-1:0] fb_rdata_a
);

    logic              cpu_gnt_s;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_hold_r;

    // Load return: flag the cycle after a granted load and keep the last data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r     <= 1'b0;
            rdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= cpu_gnt_s & ~cpu_we;
            if (rvalid_r) begin
                rdata_hold_r <= fb_rdata_a;
            end else begin
                rdata_hold_r <= rdata_hold_r;
            end
        end
    end

    // Port A read data arrives in the rvalid cycle itself, so it is passed
    // straight through then and held afterwards.
    assign cpu_rvalid = rvalid_r;
    assign cpu_rdata  = rvalid_r ? fb_rdata_a : rdata_hold_r;
    assign cpu_gnt    = cpu_gnt_s;

`ifdef FB_FILL_EN

    localparam int BURST_W = $clog2(CPU_BURST_MAX + 1);

    localparam logic [8:0]         IMG_W_9     = 9'(IMG_W);
    localparam logic [8:0]         IMG_H_9     = 9'(IMG_H);
    localparam logic [ADDR_W-1:0]  IMG_W_A     = ADDR_W'(IMG_W);
    localparam logic [BURST_W-1:0] BURST_MAX_B = BURST_W'(CPU_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    fill_state_t        state_r;
    fill_state_t        next_state_s;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         x0_r;
    logic [7:0]         y0_r;
    logic [7:0]         w_r;
    logic [7:0]         h_r;
    logic [DATA_W-1:0]  color_r;
    logic [8:0]         x_end_r;
    logic [8:0]         y_end_r;
    logic [8:0]         cur_x_r;
    logic [8:0]         cur_y_r;
    logic [ADDR_W-1:0]  row_base_r;
    logic [BURST_W-1:0] burst_r;

    logic [8:0]         x_sum_s;
    logic [8:0]         y_sum_s;
    logic               empty_s;
    logic               in_run_s;
    logic               cpu_win_s;
    logic               fill_slot_s;
    logic               row_end_s;
    logic               last_s;
    logic [ADDR_W-1:0]  fill_addr_s;

    // Clipping, arbitration and fill-address decode
    always_comb begin
        x_sum_s     = {1'b0, x0_r} + {1'b0, w_r};
        y_sum_s     = {1'b0, y0_r} + {1'b0, h_r};
        empty_s     = (w_r == 8'd0) || (h_r == 8'd0) ||
                      ({1'b0, x0_r} >= IMG_W_9) || ({1'b0, y0_r} >= IMG_H_9);
        in_run_s    = (state_r == ST_RUN);
        cpu_win_s   = cpu_req && (burst_r < BURST_MAX_B);
        fill_slot_s = in_run_s && !cpu_win_s;
        if (in_run_s) begin
            cpu_gnt_s = cpu_win_s;
        end else begin
            cpu_gnt_s = cpu_req;
        end
        row_end_s   = ((cur_x_r + 9'd1) == x_end_r);
        last_s      = row_end_s && ((cur_y_r + 9'd1) == y_end_r);
        fill_addr_s = row_base_r + ADDR_W'(cur_x_r);
    end

    // Fill FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) begin
                    next_state_s = ST_CLIP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLIP: begin
                if (empty_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fill_slot_s && last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Port A mux: fill slot, CPU slot, or idle
    always_comb begin
        fb_addr_a  = {ADDR_W{1'b0}};
        fb_we_a    = 1'b0;
        fb_wdata_a = {DATA_W{1'b0}};
        if (fill_slot_s) begin
            fb_addr_a  = fill_addr_s;
            fb_we_a    = 1'b1;
            fb_wdata_a = color_r;
        end else if (cpu_gnt_s) begin
            fb_addr_a  = cpu_addr;
            fb_we_a    = cpu_we;
            fb_wdata_a = cpu_wdata;
        end else begin
            fb_addr_a  = {ADDR_W{1'b0}};
        end
    end

    // FSM state plus registered busy/done flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Consecutive CPU wins inside RUN; cleared by any fill slot or leaving RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (in_run_s && (next_state_s == ST_RUN) && cpu_win_s) begin
            burst_r <= burst_r + {{(BURST_W-1){1'b0}}, 1'b1};
        end else begin
            burst_r <= {BURST_W{1'b0}};
        end
    end

    // Request latch, clipping results and raster walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r       <= 8'd0;
            y0_r       <= 8'd0;
            w_r        <= 8'd0;
            h_r        <= 8'd0;
            color_r    <= {DATA_W{1'b0}};
            x_end_r    <= 9'd0;
            y_end_r    <= 9'd0;
            cur_x_r    <= 9'd0;
            cur_y_r    <= 9'd0;
            row_base_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fill_start) begin
                        x0_r    <= fill_x0;
                        y0_r    <= fill_y0;
                        w_r     <= fill_w;
                        h_r     <= fill_h;
                        color_r <= fill_color;
                    end else begin
                        color_r <= color_r;
                    end
                end
                ST_CLIP: begin
                    x_end_r    <= (x_sum_s > IMG_W_9) ? IMG_W_9 : x_sum_s;
                    y_end_r    <= (y_sum_s > IMG_H_9) ? IMG_H_9 : y_sum_s;
                    cur_x_r    <= {1'b0, x0_r};
                    cur_y_r    <= {1'b0, y0_r};
                    row_base_r <= ADDR_W'(y0_r) * IMG_W_A;
                end
                ST_RUN: begin
                    if (fill_slot_s) begin
                        if (row_end_s) begin
                            cur_x_r    <= {1'b0, x0_r};
                            cur_y_r    <= cur_y_r + 9'd1;
                            row_base_r <= row_base_r + IMG_W_A;
                        end else begin
                            cur_x_r    <= cur_x_r + 9'd1;
                        end
                    end else begin
                        cur_x_r <= cur_x_r;
                    end
                end
                default: begin
                    cur_x_r <= cur_x_r;
                end
            endcase
        end
    end

    assign fill_busy = busy_r;
    assign fill_done = done_r;

`else

    logic unused_fill_s;

    // CPU owns port A outright when the fill engine is not built
    always_comb begin
        cpu_gnt_s  = cpu_req;
        fb_addr_a  = {ADDR_W{1'b0}};
        fb_we_a    = 1'b0;
        fb_wdata_a = {DATA_W{1'b0}};
        if (cpu_req) begin
            fb_addr_a  = cpu_addr;
            fb_we_a    = cpu_we;
            fb_wdata_a = cpu_wdata;
        end else begin
            fb_we_a    = 1'b0;
        end
    end

    assign unused_fill_s = &{1'b0, fill_start, fill_x0, fill_y0, fill_w,
                             fill_h, fill_color};
    assign fill_busy     = 1'b0;
    assign fill_done     = 1'b0;

`endif

endmodule

// File: tb/tb_fb_port_a_sched.sv
// -----------------------------------------------------------------------------
// tb_fb_port_a_sched
//
// Directed bench for fb_port_a_sched. A behavioural framebuffer with one
// cycle of read latency sits on port A. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. The fill scenarios are
// exercised when FB_FILL_EN is defined, the CPU-only behaviour otherwise.
// -----------------------------------------------------------------------------
module tb_fb_port_a_sched;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              fill_start;
    logic [7:0]        fill_x0;
    logic [7:0]        fill_y0;
    logic [7:0]        fill_w;
    logic [7:0]        fill_h;
    logic [DATA_W-1:0] fill_color;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] fb_addr_a;
    logic              fb_we_a;
    logic [DATA_W-1:0] fb_wdata_a;
    logic [DATA_W-1:0] fb_rdata_a;

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    int vec_cnt;
    int miscompare_cnt;

    fb_port_a_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fb_addr_a  (fb_addr_a),
        .fb_we_a    (fb_we_a),
        .fb_wdata_a (fb_wdata_a),
        .fb_rdata_a (fb_rdata_a)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Framebuffer model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (fb_we_a) begin
            mem_r[fb_addr_a] <= fb_wdata_a;
        end
        fb_rdata_a <= mem_r[fb_addr_a];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a fill request for one cycle; returns in the CLIP cycle
    task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] w, input logic [7:0] h,
                              input logic [15:0] color);
        fill_x0    = x0;
        fill_y0    = y0;
        fill_w     = w;
        fill_h     = h;
        fill_color = color;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
    endtask

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_r[i] = 16'h0000;
        end
        mem_r[100] = 16'hBEEF;
        fb_rdata_a = 16'h0000;
        rst_n      = 1'b0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 15'd0;
        cpu_wdata  = 16'h0000;
        fill_start = 1'b0;
        fill_x0    = 8'd0;
        fill_y0    = 8'd0;
        fill_w     = 8'd0;
        fill_h     = 8'd0;
        fill_color = 16'h0000;

        // ---- reset state ----
        step();
        @(negedge clk);
        chk_eq("rst_gnt_follows_req", {31'd0, cpu_gnt}, 32'd1);
        chk_eq("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk_eq("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk_eq("rst_busy", {31'd0, fill_busy}, 32'd0);
        chk_eq("rst_done", {31'd0, fill_done}, 32'd0);
        cpu_req = 1'b0;
        #1;
        chk_eq("rst_gnt_low", {31'd0, cpu_gnt}, 32'd0);
        chk_eq("rst_we", {31'd0, fb_we_a}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ---- load from address 100 ----
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 15'd100;
        @(negedge clk);
        chk_eq("ld_gnt", {31'd0, cpu_gnt}, 32'd1);
        chk_eq("ld_addr", {17'd0, fb_addr_a}, 32'd100);
        chk_eq("ld_we", {31'd0, fb_we_a}, 32'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        chk_eq("ld_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk_eq("ld_rdata", {16'd0, cpu_rdata}, 32'h0000BEEF);
        step();
        @(negedge clk);
        chk_eq("ld_rvalid_drop", {31'd0, cpu_rvalid}, 32'd0);
        chk_eq("ld_rdata_hold", {16'd0, cpu_rdata}, 32'h0000BEEF);

        // ---- store then load back ----
        step();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'd200;
        cpu_wdata = 16'h1234;
        @(negedge clk);
        chk_eq("st_we", {31'd0, fb_we_a}, 32'd1);
        chk_eq("st_wdata", {16'd0, fb_wdata_a}, 32'h00001234);
        step();
        cpu_we = 1'b0;
        @(negedge clk);
        chk_eq("st_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        chk_eq("rb_rdata", {16'd0, cpu_rdata}, 32'h00001234);
        step();

`ifdef FB_FILL_EN
        begin
            logic [14:0] exp_addr [0:5];
            logic [14:0] exp_clip [0:1];
            int          wr_cnt;
            int          bad_cnt;
            exp_addr[0] = 15'd985;
            exp_addr[1] = 15'd986;
            exp_addr[2] = 15'd987;
            exp_addr[3] = 15'd1180;
            exp_addr[4] = 15'd1181;
            exp_addr[5] = 15'd1182;
            exp_clip[0] = 15'd28468;
            exp_clip[1] = 15'd28469;

            // ---- uncontended 3x2 fill ----
            start_fill(8'd10, 8'd5, 8'd3, 8'd2, 16'hF800);
            @(negedge clk);
            chk_eq("uf_clip_busy", {31'd0, fill_busy}, 32'd1);
            chk_eq("uf_clip_we", {31'd0, fb_we_a}, 32'd0);
            for (int i = 0; i < 6; i++) begin
                step();
                @(negedge clk);
                chk_eq("uf_we", {31'd0, fb_we_a}, 32'd1);
                chk_eq("uf_addr", {17'd0, fb_addr_a}, {17'd0, exp_addr[i]});
                chk_eq("uf_data", {16'd0, fb_wdata_a}, 32'h0000F800);
            end
            step();
            @(negedge clk);
            chk_eq("uf_done", {31'd0, fill_done}, 32'd1);
            chk_eq("uf_done_we", {31'd0, fb_we_a}, 32'd0);
            step();
            @(negedge clk);
            chk_eq("uf_busy_drop", {31'd0, fill_busy}, 32'd0);
            chk_eq("uf_done_drop", {31'd0, fill_done}, 32'd0);
            step();

            // ---- clipped corner fill ----
            start_fill(8'd193, 8'd145, 8'd10, 8'd10, 16'h001F);
            for (int i = 0; i < 2; i++) begin
                step();
                @(negedge clk);
                chk_eq("clip_we", {31'd0, fb_we_a}, 32'd1);
                chk_eq("clip_addr", {17'd0, fb_addr_a}, {17'd0, exp_clip[i]});
            end
            step();
            @(negedge clk);
            chk_eq("clip_done", {31'd0, fill_done}, 32'd1);
            chk_eq("clip_done_we", {31'd0, fb_we_a}, 32'd0);
            step();

            // ---- empty fills: zero width, origin off the right edge ----
            for (int k = 0; k < 2; k++) begin
                start_fill((k == 0) ? 8'd4 : 8'd200, 8'd3,
                           (k == 0) ? 8'd0 : 8'd5, 8'd4, 16'hFFFF);
                @(negedge clk);
                chk_eq("empty_clip_we", {31'd0, fb_we_a}, 32'd0);
                chk_eq("empty_clip_done", {31'd0, fill_done}, 32'd0);
                step();
                @(negedge clk);
                chk_eq("empty_done", {31'd0, fill_done}, 32'd1);
                chk_eq("empty_done_we", {31'd0, fb_we_a}, 32'd0);
                step();
                @(negedge clk);
                chk_eq("empty_idle_busy", {31'd0, fill_busy}, 32'd0);
                step();
            end

            // ---- starvation: 4x1 fill against a continuous CPU load ----
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_addr = 15'd7;
            fill_x0    = 8'd0;
            fill_y0    = 8'd0;
            fill_w     = 8'd4;
            fill_h     = 8'd1;
            fill_color = 16'h07E0;
            fill_start = 1'b1;
            @(negedge clk);
            chk_eq("stv_start_gnt", {31'd0, cpu_gnt}, 32'd1);
            step();
            fill_start = 1'b0;
            @(negedge clk);
            chk_eq("stv_clip_gnt", {31'd0, cpu_gnt}, 32'd1);
            for (int k = 0; k < 20; k++) begin
                step();
                @(negedge clk);
                if ((k % 5) == 4) begin
                    chk_eq("stv_fill_gnt", {31'd0, cpu_gnt}, 32'd0);
                    chk_eq("stv_fill_we", {31'd0, fb_we_a}, 32'd1);
                    chk_eq("stv_fill_addr", {17'd0, fb_addr_a}, k / 5);
                end else begin
                    chk_eq("stv_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
                    chk_eq("stv_cpu_we", {31'd0, fb_we_a}, 32'd0);
                    chk_eq("stv_cpu_addr", {17'd0, fb_addr_a}, 32'd7);
                end
            end
            step();
            @(negedge clk);
            chk_eq("stv_done", {31'd0, fill_done}, 32'd1);
            chk_eq("stv_done_gnt", {31'd0, cpu_gnt}, 32'd1);
            cpu_req = 1'b0;
            step();
            step();

            // ---- reset after 50 writes of a 20x20 fill ----
            start_fill(8'd0, 8'd0, 8'd20, 8'd20, 16'hAAAA);
            wr_cnt = 0;
            for (int k = 0; k < 50; k++) begin
                step();
                @(negedge clk);
                if (fb_we_a) begin
                    wr_cnt++;
                end
                if (k == 49) begin
                    chk_eq("mid_addr50", {17'd0, fb_addr_a}, 32'd399);
                end
            end
            chk_eq("mid_wr_cnt", wr_cnt, 32'd50);
            step();
            rst_n = 1'b0;
            @(negedge clk);
            chk_eq("mid_rst_we", {31'd0, fb_we_a}, 32'd0);
            chk_eq("mid_rst_busy", {31'd0, fill_busy}, 32'd0);
            chk_eq("mid_rst_done", {31'd0, fill_done}, 32'd0);
            step();
            rst_n = 1'b1;
            bad_cnt = 0;
            for (int k = 0; k < 450; k++) begin
                step();
                @(negedge clk);
                if (fb_we_a || fill_done || fill_busy) begin
                    bad_cnt++;
                end
            end
            chk_eq("mid_after_quiet", bad_cnt, 32'd0);
        end
`else
        begin
            int gnt_bad;
            // ---- fill_start is ignored, CPU keeps the port ----
            start_fill(8'd10, 8'd5, 8'd3, 8'd2, 16'hF800);
            @(negedge clk);
            chk_eq("nf_busy", {31'd0, fill_busy}, 32'd0);
            chk_eq("nf_we", {31'd0, fb_we_a}, 32'd0);
            gnt_bad = 0;
            cpu_req  = 1'b1;
            cpu_we   = 1'b1;
            cpu_addr = 15'd300;
            cpu_wdata = 16'h5A5A;
            for (int k = 0; k < 10; k++) begin
                step();
                @(negedge clk);
                if (!cpu_gnt || !fb_we_a || fill_done || fill_busy ||
                    (fb_addr_a != 15'd300)) begin
                    gnt_bad++;
                end
            end
            chk_eq("nf_cpu_owns_port", gnt_bad, 32'd0);
            chk_eq("nf_wdata", {16'd0, fb_wdata_a}, 32'h00005A5A);
            cpu_req = 1'b0;
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
